// File: rtl/brb_tag_tracker.sv
// brb_tag_tracker: allocates branch speculation slots and turns resolution broadcasts into one-cycle clear/kill masks
module brb_tag_tracker #(
  parameter int NUM_BR = 4,
  parameter int COB_ADDR_WIDTH = 4,
  parameter int TAG_WIDTH = COB_ADDR_WIDTH,
  localparam int CW = $clog2(NUM_BR + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 alloc_req,
  input  logic [TAG_WIDTH-1:0] alloc_tag,
  output logic                 alloc_ready,
  output logic [NUM_BR-1:0]    alloc_id,
  output logic [NUM_BR-1:0]    spec_mask,
  input  logic                 brb_broadcast,
  input  logic                 brb_clean,
  input  logic                 brb_kill,
  input  logic [TAG_WIDTH-1:0] brb_tag,
  output logic [NUM_BR-1:0]    clear_mask,
  output logic [NUM_BR-1:0]    kill_mask,
  output logic                 tag_miss,
  output logic [CW-1:0]        count
);
  logic [NUM_BR-1:0]                valid_q, valid_d;
  logic [NUM_BR-1:0][TAG_WIDTH-1:0] tag_q, tag_d;
  logic [NUM_BR-1:0][NUM_BR-1:0]    dep_q, dep_d;
  logic [NUM_BR-1:0]                clear_mask_q, clear_mask_d;
  logic [NUM_BR-1:0]                kill_mask_q, kill_mask_d;
  logic                             tag_miss_q, tag_miss_d;
  logic [CW-1:0]                    count_q, count_d;
  logic [NUM_BR-1:0]                hit, free, clean_set, kill_set;
  logic                             any_hit, kill_now, do_kill, do_clean, do_alloc;

  always_comb begin
    for (int i = 0; i < NUM_BR; i++) hit[i] = valid_q[i] && (tag_q[i] == brb_tag);
    any_hit = |hit;
    kill_now = brb_broadcast & brb_kill;
    do_kill = kill_now & any_hit;
    do_clean = brb_broadcast & brb_clean & ~brb_kill & any_hit;
    clean_set = do_clean ? hit : '0;
    // a kill takes the matched slot plus every slot that depends on it
    for (int i = 0; i < NUM_BR; i++) kill_set[i] = do_kill & (hit[i] | (|(dep_q[i] & hit)));
    free = ~valid_q;
    alloc_id = free & (~free + NUM_BR'(1));
    alloc_ready = (count_q < CW'(NUM_BR)) & ~kill_now;
    do_alloc = alloc_req & alloc_ready;
    valid_d = (valid_q & ~kill_set & ~clean_set) | (do_alloc ? alloc_id : '0);
    count_d = '0;
    for (int i = 0; i < NUM_BR; i++) begin
      tag_d[i] = (do_alloc & alloc_id[i]) ? alloc_tag : tag_q[i];
      dep_d[i] = (do_alloc & alloc_id[i]) ? (valid_q & ~clean_set) :
                 valid_d[i] ? (dep_q[i] & ~(clean_set | kill_set)) : '0;
      count_d = count_d + CW'(valid_d[i]);
    end
    clear_mask_d = clean_set;
    kill_mask_d = kill_set;
    tag_miss_d = brb_broadcast & (brb_clean | brb_kill) & ~any_hit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      tag_q <= '0;
      dep_q <= '0;
      clear_mask_q <= '0;
      kill_mask_q <= '0;
      tag_miss_q <= 1'b0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      tag_q <= tag_d;
      dep_q <= dep_d;
      clear_mask_q <= clear_mask_d;
      kill_mask_q <= kill_mask_d;
      tag_miss_q <= tag_miss_d;
      count_q <= count_d;
    end
  end

  assign spec_mask = valid_q;
  assign count = count_q;
  assign clear_mask = clear_mask_q;
  assign kill_mask = kill_mask_q;
  assign tag_miss = tag_miss_q;
endmodule

// File: tb/tb_brb_tag_tracker.sv
// tb_brb_tag_tracker: directed stimulus checked against an age-ordered slot model plus literal expectations
module tb_brb_tag_tracker;
  logic       clk, rst_n;
  logic       alloc_req, alloc_ready;
  logic [3:0] alloc_tag, alloc_id, spec_mask;
  logic       brb_broadcast, brb_clean, brb_kill;
  logic [3:0] brb_tag, clear_mask, kill_mask;
  logic       tag_miss;
  logic [2:0] count;
  int checks = 0, errors = 0;

  brb_tag_tracker #(.NUM_BR(4), .COB_ADDR_WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .alloc_req(alloc_req), .alloc_tag(alloc_tag),
    .alloc_ready(alloc_ready), .alloc_id(alloc_id), .spec_mask(spec_mask),
    .brb_broadcast(brb_broadcast), .brb_clean(brb_clean), .brb_kill(brb_kill),
    .brb_tag(brb_tag), .clear_mask(clear_mask), .kill_mask(kill_mask),
    .tag_miss(tag_miss), .count(count)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // Model: a kill removes the matched branch and every live branch allocated after it.
  logic [3:0] m_valid, n_valid, m_clr, n_clr, m_kill, n_kill;
  logic       m_miss, n_miss;
  int         m_tag[4], n_tag[4], m_seq[4], n_seq[4], m_seqn, n_seqn;
  logic [3:0] exp_id;
  int         exp_count, match, slot;
  logic       exp_ready, kil, cln;

  always_comb begin
    exp_count = 0;
    exp_id = '0;
    slot = -1;
    for (int i = 0; i < 4; i++) begin
      exp_count += int'(m_valid[i]);
      if (!m_valid[i] && slot < 0) slot = i;
    end
    if (slot >= 0) exp_id[slot] = 1'b1;
    exp_ready = exp_count < 4 && !(brb_broadcast && brb_kill);
    match = -1;
    for (int i = 0; i < 4; i++) if (m_valid[i] && m_tag[i] == int'(brb_tag)) match = i;
    kil = brb_broadcast && brb_kill && match >= 0;
    cln = brb_broadcast && brb_clean && !brb_kill && match >= 0;
    n_valid = m_valid;
    n_tag = m_tag;
    n_seq = m_seq;
    n_seqn = m_seqn;
    n_clr = '0;
    n_kill = '0;
    n_miss = brb_broadcast && (brb_clean || brb_kill) && match < 0;
    if (kil)
      for (int j = 0; j < 4; j++)
        if (m_valid[j] && (j == match || m_seq[j] > m_seq[match])) begin
          n_valid[j] = 1'b0;
          n_kill[j] = 1'b1;
        end
    if (cln) begin
      n_valid[match] = 1'b0;
      n_clr[match] = 1'b1;
    end
    if (alloc_req && exp_ready) begin
      n_valid[slot] = 1'b1;
      n_tag[slot] = int'(alloc_tag);
      n_seq[slot] = m_seqn;
      n_seqn = m_seqn + 1;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= '0;
      m_clr <= '0;
      m_kill <= '0;
      m_miss <= 1'b0;
      m_seqn <= 0;
      for (int i = 0; i < 4; i++) begin
        m_tag[i] <= 0;
        m_seq[i] <= 0;
      end
    end else begin
      m_valid <= n_valid;
      m_clr <= n_clr;
      m_kill <= n_kill;
      m_miss <= n_miss;
      m_seqn <= n_seqn;
      m_tag <= n_tag;
      m_seq <= n_seq;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("spec_mask", 32'(spec_mask), 32'(m_valid));
    chk("count", 32'(count), 32'(exp_count));
    chk("alloc_ready", 32'(alloc_ready), 32'(exp_ready));
    chk("alloc_id", 32'(alloc_id), 32'(exp_id));
    chk("clear_mask", 32'(clear_mask), 32'(m_clr));
    chk("kill_mask", 32'(kill_mask), 32'(m_kill));
    chk("tag_miss", 32'(tag_miss), 32'(m_miss));
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic alloc(input logic [3:0] t);
    alloc_req = 1;
    alloc_tag = t;
    tick();
    alloc_req = 0;
  endtask

  task automatic bcast(input logic c, input logic k, input logic [3:0] t);
    brb_broadcast = 1;
    brb_clean = c;
    brb_kill = k;
    brb_tag = t;
  endtask

  task automatic bidle;
    brb_broadcast = 0;
    brb_clean = 0;
    brb_kill = 0;
  endtask

  task automatic do_reset;
    #2 rst_n = 0;
    #10 rst_n = 1;
    tick();
  endtask

  initial begin
    logic [3:0] tags[4] = '{4'd5, 4'd9, 4'd12, 4'd3};
    rst_n = 0;
    alloc_req = 0;
    alloc_tag = 0;
    brb_tag = 0;
    bidle();
    repeat (2) @(posedge clk);
    #3 rst_n = 1;
    tick();
    settle();
    chk("rst_spec", 32'(spec_mask), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_ready", 32'(alloc_ready), 1);
    chk("rst_id", 32'(alloc_id), 1);
    for (int k = 0; k < 4; k++) begin
      alloc_req = 1;
      alloc_tag = tags[k];
      settle();
      chk("fill_id", 32'(alloc_id), 32'(1) << k);
      tick();
    end
    alloc_req = 0;
    settle();
    chk("full_spec", 32'(spec_mask), 32'hf);
    chk("full_count", 32'(count), 4);
    chk("full_ready", 32'(alloc_ready), 0);
    bcast(1, 0, 9);
    tick();
    bidle();
    settle();
    chk("clean9_clear", 32'(clear_mask), 32'h2);
    chk("clean9_kill", 32'(kill_mask), 0);
    chk("clean9_spec", 32'(spec_mask), 32'hd);
    chk("clean9_count", 32'(count), 3);
    tick();
    chk("clean9_pulse_end", 32'(clear_mask), 0);
    bcast(1, 0, 5);
    tick();
    bcast(1, 0, 12);
    settle();
    chk("b2b_clear1", 32'(clear_mask), 32'h1);
    tick();
    bidle();
    settle();
    chk("b2b_clear2", 32'(clear_mask), 32'h4);
    chk("b2b_spec", 32'(spec_mask), 32'h8);
    do_reset();
    for (int k = 0; k < 4; k++) alloc(tags[k]);
    bcast(0, 1, 9);
    tick();
    bidle();
    settle();
    chk("kill9_kill", 32'(kill_mask), 32'he);
    chk("kill9_spec", 32'(spec_mask), 32'h1);
    chk("kill9_count", 32'(count), 1);
    tick();
    alloc(9);
    bcast(1, 0, 5);
    alloc_req = 1;
    alloc_tag = 7;
    settle();
    chk("cln_alloc_ready", 32'(alloc_ready), 1);
    chk("cln_alloc_id", 32'(alloc_id), 32'h4);
    tick();
    alloc_req = 0;
    bidle();
    settle();
    chk("cln_alloc_clear", 32'(clear_mask), 32'h1);
    chk("cln_alloc_count", 32'(count), 2);
    chk("cln_alloc_spec", 32'(spec_mask), 32'h6);
    bcast(0, 1, 9);
    tick();
    bidle();
    settle();
    chk("dep_kill", 32'(kill_mask), 32'h6);
    chk("dep_spec", 32'(spec_mask), 0);
    do_reset();
    alloc(5);
    alloc(9);
    bcast(0, 1, 5);
    alloc_req = 1;
    alloc_tag = 7;
    settle();
    chk("kill_alloc_ready", 32'(alloc_ready), 0);
    tick();
    alloc_req = 0;
    bidle();
    settle();
    chk("kill_alloc_kill", 32'(kill_mask), 32'h3);
    chk("kill_alloc_count", 32'(count), 0);
    alloc(5);
    bcast(1, 0, 15);
    tick();
    bidle();
    settle();
    chk("miss_pulse", 32'(tag_miss), 1);
    chk("miss_clear", 32'(clear_mask), 0);
    chk("miss_kill", 32'(kill_mask), 0);
    chk("miss_spec", 32'(spec_mask), 32'h1);
    tick();
    chk("miss_end", 32'(tag_miss), 0);
    do_reset();
    alloc(1);
    alloc(2);
    alloc(3);
    bcast(1, 0, 1);
    tick();
    bidle();
    settle();
    chk("pend_clear", 32'(clear_mask), 32'h1);
    #1 rst_n = 0;
    #1;
    chk("mid_rst_clear", 32'(clear_mask), 0);
    chk("mid_rst_spec", 32'(spec_mask), 0);
    chk("mid_rst_count", 32'(count), 0);
    tick();
    #2 rst_n = 1;
    tick();
    chk("post_rst_ready", 32'(alloc_ready), 1);
    bcast(1, 0, 2);
    tick();
    bidle();
    settle();
    chk("stale_miss", 32'(tag_miss), 1);
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
